// File: rtl/cache_tag_array_nway_if.sv
// -----------------------------------------------------------------------------
// cache_tag_array_nway_if
// Request/response bundle between a cache controller and the N-way tag store.
//   lookup_valid/lookup_tag/lookup_index : hit check request (controller -> store)
//   hit/hit_way/victim_way               : combinational lookup response
//   fill_en/fill_way/fill_index/fill_tag : tag write and LRU promote
//   inv_req                              : one-cycle pulse, invalidate all sets
//   inv_busy/inv_done                    : sweep status (registered)
// The master modport is the cache controller; the slave modport is the store.
// -----------------------------------------------------------------------------
interface cache_tag_array_nway_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 32,
  parameter int TAG_W = 21
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);

  logic             lookup_valid;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] lookup_index;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             fill_en;
  logic [WAY_W-1:0] fill_way;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;
  logic             inv_req;
  logic             inv_busy;
  logic             inv_done;

  modport master (
    output lookup_valid, lookup_tag, lookup_index,
    output fill_en, fill_way, fill_index, fill_tag,
    output inv_req,
    input  hit, hit_way, victim_way,
    input  inv_busy, inv_done
  );

  modport slave (
    input  lookup_valid, lookup_tag, lookup_index,
    input  fill_en, fill_way, fill_index, fill_tag,
    input  inv_req,
    output hit, hit_way, victim_way,
    output inv_busy, inv_done
  );
endinterface

// File: rtl/cache_tag_array_nway.sv
// -----------------------------------------------------------------------------
// cache_tag_array_nway
// N-way set-associative tag store with true-LRU replacement.
//   clk     : clock
//   rrst_n  : asynchronous active-low reset
//   bus     : cache_tag_array_nway_if.slave (lookup, fill, invalidate)
// Per set/way the store keeps a valid bit, a tag and an age (0 = MRU,
// WAYS-1 = LRU). Hit and victim are combinational on lookup_index. LRU
// state changes on the edge after a hit or fill. inv_req launches a sweep
// that clears one set per cycle; while the sweep (or its done cycle) is in
// progress the store answers misses and accepts no updates.
// -----------------------------------------------------------------------------
module cache_tag_array_nway #(
  parameter int WAYS  = 4,
  parameter int SETS  = 32,
  parameter int TAG_W = 21
) (
  input  logic                   clk,
  input  logic                   rrst_n,
  cache_tag_array_nway_if.slave  bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);

  typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } inv_state_t;

  // Storage
  logic [WAYS-1:0]  valid_r [SETS];
  logic [TAG_W-1:0] tag_r   [SETS][WAYS];
  age_vec_t         age_r   [SETS];

  // Invalidation sweep
  inv_state_t       state_r;
  logic [IDX_W-1:0] ptr_r;
  logic             inv_busy_r;
  logic             inv_done_r;

  // Lookup datapath
  logic [WAYS-1:0]  match_s;
  logic [WAY_W-1:0] first_match_s;
  logic [WAY_W-1:0] first_invalid_s;
  logic [WAY_W-1:0] lru_way_s;
  logic             any_invalid_s;
  logic             hit_s;
  logic [WAY_W-1:0] hit_way_s;
  logic [WAY_W-1:0] victim_way_s;
  logic             idle_s;
  logic             fill_upd_s;
  logic             hit_upd_s;

  // Age vector of a freshly reset or swept set: age[w] = w.
  function automatic age_vec_t age_reset_vec();
    age_vec_t res;
    for (int w = 0; w < WAYS; w++) begin
      res[w] = WAY_W'(w);
    end
    return res;
  endfunction

  // True-LRU promote: the touched way becomes MRU, every way that was
  // younger than it ages by one, older ways keep their age. This keeps the
  // ages a permutation of 0..WAYS-1.
  function automatic age_vec_t lru_touch(input age_vec_t ages,
                                         input logic [WAY_W-1:0] way);
    age_vec_t         res;
    logic [WAY_W-1:0] old_age;
    old_age = ages[way];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == way) begin
        res[w] = {WAY_W{1'b0}};
      end else if (ages[w] < old_age) begin
        res[w] = ages[w] + WAY_W'(1'b1);
      end else begin
        res[w] = ages[w];
      end
    end
    return res;
  endfunction

  // Tag compare, priority encoders for hit/invalid/LRU way, victim choice.
  always_comb begin
    match_s         = {WAYS{1'b0}};
    first_match_s   = {WAY_W{1'b0}};
    first_invalid_s = {WAY_W{1'b0}};
    lru_way_s       = {WAY_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = valid_r[bus.lookup_index][w] &&
                   (tag_r[bus.lookup_index][w] == bus.lookup_tag);
    end
    // Scan downwards so the lowest qualifying way is the last one written.
    for (int w = WAYS - 1; w >= 0; w--) begin
      first_match_s   = match_s[w] ? WAY_W'(w) : first_match_s;
      first_invalid_s = !valid_r[bus.lookup_index][w] ? WAY_W'(w) : first_invalid_s;
      lru_way_s       = (age_r[bus.lookup_index][w] == WAY_W'(WAYS - 1)) ?
                        WAY_W'(w) : lru_way_s;
    end
    any_invalid_s = ~(&valid_r[bus.lookup_index]);
    idle_s        = (state_r == ST_IDLE);
    // Misses are forced for the whole sweep including its done cycle.
    hit_s         = bus.lookup_valid & idle_s & (|match_s);
    hit_way_s     = hit_s ? first_match_s : {WAY_W{1'b0}};
    if (inv_busy_r) begin
      victim_way_s = {WAY_W{1'b0}};
    end else if (any_invalid_s) begin
      victim_way_s = first_invalid_s;
    end else begin
      victim_way_s = lru_way_s;
    end
    fill_upd_s = bus.fill_en & idle_s;
    // A fill to the same set wins; the filled way must end as MRU.
    hit_upd_s  = hit_s & ~(fill_upd_s & (bus.lookup_index == bus.fill_index));
  end

  assign bus.hit        = hit_s;
  assign bus.hit_way    = hit_way_s;
  assign bus.victim_way = victim_way_s;
  assign bus.inv_busy   = inv_busy_r;
  assign bus.inv_done   = inv_done_r;

  // Valid/tag/age storage: reset, sweep clear, fill write and LRU promotes.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        age_r[s]   <= age_reset_vec();
        for (int w = 0; w < WAYS; w++) begin
          tag_r[s][w] <= {TAG_W{1'b0}};
        end
      end
    end else begin
      if (state_r == ST_SWEEP) begin
        valid_r[ptr_r] <= {WAYS{1'b0}};
        age_r[ptr_r]   <= age_reset_vec();
      end else if (state_r == ST_IDLE) begin
        if (hit_upd_s) begin
          age_r[bus.lookup_index] <= lru_touch(age_r[bus.lookup_index], hit_way_s);
        end
        if (fill_upd_s) begin
          valid_r[bus.fill_index][bus.fill_way] <= 1'b1;
          tag_r[bus.fill_index][bus.fill_way]   <= bus.fill_tag;
          age_r[bus.fill_index] <= lru_touch(age_r[bus.fill_index], bus.fill_way);
        end
      end
    end
  end

  // Invalidation FSM: IDLE -> SWEEP (SETS cycles) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {IDX_W{1'b0}};
      inv_busy_r <= 1'b0;
      inv_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          inv_done_r <= 1'b0;
          if (bus.inv_req) begin
            state_r    <= ST_SWEEP;
            ptr_r      <= {IDX_W{1'b0}};
            inv_busy_r <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (ptr_r == IDX_W'(SETS - 1)) begin
            state_r    <= ST_DONE;
            ptr_r      <= {IDX_W{1'b0}};
            inv_busy_r <= 1'b0;
            inv_done_r <= 1'b1;
          end else begin
            ptr_r <= ptr_r + IDX_W'(1'b1);
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          inv_done_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          ptr_r      <= {IDX_W{1'b0}};
          inv_busy_r <= 1'b0;
          inv_done_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_tag_array_nway.sv
// -----------------------------------------------------------------------------
// tb_cache_tag_array_nway
// Directed bench for cache_tag_array_nway (WAYS=4, SETS=32, TAG_W=21).
// The driver pushes expected lookup responses and expected sweep lengths
// into queues; a monitor on the falling edge pops and compares whenever a
// lookup is presented or inv_done pulses.
// -----------------------------------------------------------------------------
module tb_cache_tag_array_nway;
  localparam int WAYS  = 4;
  localparam int SETS  = 32;
  localparam int TAG_W = 21;

  typedef logic [3:0][1:0] ages_t;

  typedef struct {
    string name;
    logic  hit;
    logic [1:0] way;
    logic [1:0] vic;
    logic  busy;
    logic  chk_age;
    int    set;
    ages_t ages;
  } exp_t;

  logic clk;
  logic rrst_n;
  int   n_cmp;
  int   n_fail;
  int   done_cnt;
  int   busy_cnt;
  exp_t lookup_q[$];
  int   sweep_q[$];

  cache_tag_array_nway_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) bus ();

  cache_tag_array_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ages_t mk(input int a0, input int a1, input int a2, input int a3);
    ages_t r;
    r[0] = 2'(a0); r[1] = 2'(a1); r[2] = 2'(a2); r[3] = 2'(a3);
    return r;
  endfunction

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  task automatic clr();
    bus.lookup_valid = 1'b0;
    bus.lookup_tag   = 21'h0;
    bus.lookup_index = 5'd0;
    bus.fill_en      = 1'b0;
    bus.fill_way     = 2'd0;
    bus.fill_index   = 5'd0;
    bus.fill_tag     = 21'h0;
    bus.inv_req      = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic look(input string name, input int tag, input int idx,
                      input logic e_hit, input int e_way, input int e_vic,
                      input logic e_busy, input logic chk_age, input ages_t ages);
    exp_t e;
    bus.lookup_valid = 1'b1;
    bus.lookup_tag   = 21'(tag);
    bus.lookup_index = 5'(idx);
    e.name = name; e.hit = e_hit; e.way = 2'(e_way); e.vic = 2'(e_vic);
    e.busy = e_busy; e.chk_age = chk_age; e.set = idx; e.ages = ages;
    lookup_q.push_back(e);
  endtask

  task automatic fill(input int idx, input int way, input int tag);
    bus.fill_en    = 1'b1;
    bus.fill_index = 5'(idx);
    bus.fill_way   = 2'(way);
    bus.fill_tag   = 21'(tag);
  endtask

  // Monitor: compares on the falling edge, away from the active clock edge.
  initial begin
    exp_t e;
    int   exp_len;
    forever begin
      @(negedge clk);
      if (!rrst_n) begin
        busy_cnt = 0;
      end else begin
        if (bus.inv_busy) busy_cnt++;
        if (bus.inv_done) begin
          done_cnt++;
          if (sweep_q.size() == 0) begin
            chk("inv_done", "unexpected", 32'd1, 32'd0);
          end else begin
            exp_len = sweep_q.pop_front();
            chk("sweep", "busy_cycles", 32'(busy_cnt), 32'(exp_len));
            chk("sweep", "busy_at_done", 32'(bus.inv_busy), 32'd0);
          end
          busy_cnt = 0;
        end
      end
      if (bus.lookup_valid) begin
        if (lookup_q.size() == 0) begin
          chk("lookup", "unexpected", 32'd1, 32'd0);
        end else begin
          e = lookup_q.pop_front();
          chk(e.name, "hit", 32'(bus.hit), 32'(e.hit));
          chk(e.name, "hit_way", 32'(bus.hit_way), 32'(e.way));
          chk(e.name, "victim_way", 32'(bus.victim_way), 32'(e.vic));
          chk(e.name, "inv_busy", 32'(bus.inv_busy), 32'(e.busy));
          if (e.chk_age) chk(e.name, "ages", 32'(dut.age_r[e.set]), 32'(e.ages));
        end
      end
    end
  end

  // Driver: directed scenarios.
  initial begin
    int d0;
    n_cmp = 0; n_fail = 0; done_cnt = 0; busy_cnt = 0;
    clr();
    rrst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rrst_n = 1'b1;
    cycle();

    // Reset state: empty set 5, ages 0..3.
    look("reset_lookup", 'h1ABCD, 5, 1'b0, 0, 0, 1'b0, 1'b1, mk(0,1,2,3)); cycle();

    // Fill set 7 ways 3,2,1,0 so ages return to 0,1,2,3 with all ways valid.
    fill(7, 3, 'h13); cycle();
    fill(7, 2, 'h12); cycle();
    fill(7, 1, 'h11); cycle();
    fill(7, 0, 'h10); cycle();
    look("hit_w2",  'h12, 7, 1'b1, 2, 3, 1'b0, 1'b1, mk(0,1,2,3)); cycle();
    look("hit_w3",  'h13, 7, 1'b1, 3, 3, 1'b0, 1'b1, mk(1,2,0,3)); cycle();
    look("hit_w2b", 'h12, 7, 1'b1, 2, 1, 1'b0, 1'b1, mk(2,3,1,0)); cycle();

    // Same-set hit + fill: only the fill promotes.
    look("same_set_hit", 'h11, 7, 1'b1, 1, 1, 1'b0, 1'b1, mk(2,3,0,1));
    fill(7, 3, 'h33); cycle();
    look("after_same_set", 'h33, 7, 1'b1, 3, 1, 1'b0, 1'b1, mk(2,3,1,0)); cycle();

    // Different-set hit + fill: both promote.
    fill(8, 2, 'h82); cycle();
    fill(8, 0, 'h80); cycle();
    look("diff_set_hit", 'h82, 8, 1'b1, 2, 1, 1'b0, 1'b1, mk(0,2,1,3));
    fill(7, 0, 'h40); cycle();
    look("diff_set7", 'h40, 7, 1'b1, 0, 1, 1'b0, 1'b1, mk(0,3,2,1)); cycle();
    look("diff_set8", 'h80, 8, 1'b1, 0, 1, 1'b0, 1'b1, mk(1,2,0,3)); cycle();

    // Invalidation sweep.
    fill(0, 0, 'h100); cycle();
    fill(31, 1, 'h1F1); cycle();
    look("pre_sweep_31", 'h1F1, 31, 1'b1, 1, 0, 1'b0, 1'b1, mk(1,0,2,3)); cycle();
    d0 = done_cnt;
    sweep_q.push_back(SETS);
    bus.inv_req = 1'b1; cycle();
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != d0) break;
      if (i == 0)  look("busy_lookup", 'h33, 7, 1'b0, 0, 0, 1'b1, 1'b0, mk(0,0,0,0));
      if (i == 10) fill(3, 2, 'h333);
      if (i == 12) bus.inv_req = 1'b1;
      cycle();
    end
    chk("sweep", "done_seen", 32'(done_cnt - d0), 32'd1);
    look("post_sweep_7",  'h33,  7,  1'b0, 0, 0, 1'b0, 1'b1, mk(0,1,2,3)); cycle();
    look("post_sweep_0",  'h100, 0,  1'b0, 0, 0, 1'b0, 1'b1, mk(0,1,2,3)); cycle();
    look("post_sweep_31", 'h1F1, 31, 1'b0, 0, 0, 1'b0, 1'b1, mk(0,1,2,3)); cycle();
    look("fill_in_sweep", 'h333, 3,  1'b0, 0, 0, 1'b0, 1'b1, mk(0,1,2,3)); cycle();

    // Reset in the middle of a sweep: no inv_done may follow.
    fill(9, 1, 'h99); cycle();
    bus.inv_req = 1'b1; cycle();
    repeat (9) cycle();
    look("busy_pre_rst", 'h99, 9, 1'b0, 0, 0, 1'b1, 1'b0, mk(0,0,0,0)); cycle();
    rrst_n = 1'b0;
    look("rst_mid_sweep", 'h99, 9, 1'b0, 0, 0, 1'b0, 1'b1, mk(0,1,2,3)); cycle();
    rrst_n = 1'b1;
    repeat (40) cycle();
    look("post_rst", 'h99, 9, 1'b0, 0, 0, 1'b0, 1'b1, mk(0,1,2,3)); cycle();
    repeat (2) cycle();

    chk("scoreboard", "lookup_q_left", 32'(lookup_q.size()), 32'd0);
    chk("scoreboard", "sweep_q_left", 32'(sweep_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
